// File: rtl/ysyx_25040129_clint_rd_arbiter_pkg.sv
// Shared response codes, FSM encoding and the address-window helper for the
// CLINT read-channel arbiter.
package ysyx_25040129_clint_rd_arbiter_pkg;

    localparam logic [1:0] YSYX_25040129_OKAY   = 2'b00;
    localparam logic [1:0] YSYX_25040129_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    typedef struct packed {
        state_t state;
        logic   gnt;
        logic   lastgnt;
    } dbg_t;

    // 33-bit compare so that base + size cannot wrap around the address space.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] size);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + {1'b0, size};
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/ysyx_25040129_rr_pick2.sv
// Two-way round-robin pick: on a tie the master that was not granted last wins.
module ysyx_25040129_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       any
);

    assign any = |req;
    assign gnt = (&req) ? ~last : req[1];

endmodule

// File: rtl/ysyx_25040129_clint_rd_arbiter.sv
// AXI4-Lite read-channel arbiter sharing the CLINT read port between IFU (m0)
// and LSU (m1); out-of-window reads are answered locally with DECERR.
module ysyx_25040129_clint_rd_arbiter
    import ysyx_25040129_clint_rd_arbiter_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE = 32'ha000_0048,
    parameter logic [31:0] CLINT_SIZE = 32'h0000_0008
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_araddr,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    output logic [31:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    input  logic [31:0] m1_araddr,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    output logic [31:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    output logic [31:0] s_araddr,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rvalid,
    output logic        s_rready,
    output dbg_t        dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and rvalid/rdata/rresp hold until rready.
    state_t      state;
    state_t      state_next;
    logic        gnt;
    logic        lastgnt;
    logic [31:0] addr;
    logic        pick;
    logic        any;
    logic [31:0] pick_addr;
    logic        pick_ok;
    logic        gnt_rready;
    logic        done;

    ysyx_25040129_rr_pick2 u_pick (
        .req  ({m1_arvalid, m0_arvalid}),
        .last (lastgnt),
        .gnt  (pick),
        .any  (any)
    );

    assign pick_addr  = pick ? m1_araddr : m0_araddr;
    assign pick_ok    = addr_in_range(pick_addr, CLINT_BASE, CLINT_SIZE);
    assign gnt_rready = gnt ? m1_rready : m0_rready;
    assign s_araddr   = addr;
    assign dbg        = '{state: state, gnt: gnt, lastgnt: lastgnt};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            gnt     <= 1'b0;
            lastgnt <= 1'b1;
            addr    <= 32'h0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && any) begin
                gnt  <= pick;
                addr <= pick_addr;
            end
            if (done) begin
                lastgnt <= gnt;
            end
        end
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        m0_rdata   = 32'h0;
        m1_rdata   = 32'h0;
        m0_rresp   = YSYX_25040129_OKAY;
        m1_rresp   = YSYX_25040129_OKAY;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any) begin
                    m0_arready = ~pick;
                    m1_arready = pick;
                    state_next = pick_ok ? ST_AR : ST_ERR;
                end
            end
            ST_AR: begin
                s_arvalid = 1'b1;
                if (s_arready) begin
                    state_next = ST_R;
                end
            end
            ST_R: begin
                s_rready = gnt_rready;
                if (gnt) begin
                    m1_rvalid = s_rvalid;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                end else begin
                    m0_rvalid = s_rvalid;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                end
                if (s_rvalid && gnt_rready) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_ERR: begin
                // Local decode error: the slave port stays quiet.
                if (gnt) begin
                    m1_rvalid = 1'b1;
                    m1_rresp  = YSYX_25040129_DECERR;
                end else begin
                    m0_rvalid = 1'b1;
                    m0_rresp  = YSYX_25040129_DECERR;
                end
                if (gnt_rready) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_25040129_clint_rd_arbiter.sv
// Self-checking bench for the CLINT read arbiter: per-master response queues,
// a registered slave model and scenario tasks with cycle-exact checks.
module tb_ysyx_25040129_clint_rd_arbiter;
    import ysyx_25040129_clint_rd_arbiter_pkg::*;

    // Slave returns address XOR KEY, so 0xa000_0048 reads back as 0x0000_1234.
    localparam logic [31:0] KEY = 32'ha000_127c;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_araddr, m1_araddr;
    logic        m0_arvalid, m1_arvalid;
    logic        m0_arready, m1_arready;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp;
    logic        m0_rvalid, m1_rvalid;
    logic        m0_rready, m1_rready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    dbg_t        dbg;

    int checks = 0;
    int failures = 0;
    logic [33:0] exp0_q[$];
    logic [33:0] exp1_q[$];
    logic [33:0] exp_v;
    bit          grant_log[$];
    int          s_av_cycles = 0;
    logic        s_pend;
    logic [31:0] s_data;
    logic [31:0] s_last_addr;

    always #5 clk = ~clk;

    ysyx_25040129_clint_rd_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .m0_araddr  (m0_araddr),
        .m0_arvalid (m0_arvalid),
        .m0_arready (m0_arready),
        .m0_rdata   (m0_rdata),
        .m0_rresp   (m0_rresp),
        .m0_rvalid  (m0_rvalid),
        .m0_rready  (m0_rready),
        .m1_araddr  (m1_araddr),
        .m1_arvalid (m1_arvalid),
        .m1_arready (m1_arready),
        .m1_rdata   (m1_rdata),
        .m1_rresp   (m1_rresp),
        .m1_rvalid  (m1_rvalid),
        .m1_rready  (m1_rready),
        .s_araddr   (s_araddr),
        .s_arvalid  (s_arvalid),
        .s_arready  (s_arready),
        .s_rdata    (s_rdata),
        .s_rresp    (s_rresp),
        .s_rvalid   (s_rvalid),
        .s_rready   (s_rready),
        .dbg        (dbg)
    );

    // Slave model: answers one cycle after the AR handshake, holds until rready.
    assign s_rvalid = s_pend;
    assign s_rdata  = s_data;
    assign s_rresp  = 2'b00;

    always @(posedge clk) begin
        if (s_arvalid) s_av_cycles <= s_av_cycles + 1;
        if (rst) begin
            s_pend <= 1'b0;
            s_data <= 32'h0;
        end else begin
            if (s_rvalid && s_rready) s_pend <= 1'b0;
            if (s_arvalid && s_arready) begin
                s_pend      <= 1'b1;
                s_data      <= s_araddr ^ KEY;
                s_last_addr <= s_araddr;
            end
        end
    end

    function automatic logic [33:0] exp_for(input logic [31:0] a);
        if (a >= 32'ha000_0048 && a < 32'ha000_0050) return {2'b00, a ^ KEY};
        return {2'b11, 32'h0};
    endfunction

    // Response monitor: pops the per-master queue on every R handshake.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (m0_rvalid && m0_rready) begin
                checks++;
                if (exp0_q.size() == 0) begin
                    failures++;
                    $display("FAIL m0_unexpected_resp got resp=%b data=%h, expected no response", m0_rresp, m0_rdata);
                end else begin
                    exp_v = exp0_q.pop_front();
                    if ({m0_rresp, m0_rdata} !== exp_v) begin
                        failures++;
                        $display("FAIL m0_resp got resp=%b data=%h, expected resp=%b data=%h",
                                 m0_rresp, m0_rdata, exp_v[33:32], exp_v[31:0]);
                    end
                end
            end
            if (m1_rvalid && m1_rready) begin
                checks++;
                if (exp1_q.size() == 0) begin
                    failures++;
                    $display("FAIL m1_unexpected_resp got resp=%b data=%h, expected no response", m1_rresp, m1_rdata);
                end else begin
                    exp_v = exp1_q.pop_front();
                    if ({m1_rresp, m1_rdata} !== exp_v) begin
                        failures++;
                        $display("FAIL m1_resp got resp=%b data=%h, expected resp=%b data=%h",
                                 m1_rresp, m1_rdata, exp_v[33:32], exp_v[31:0]);
                    end
                end
            end
            if (m0_rvalid || m1_rvalid) begin
                checks++;
                if (m0_rvalid && m1_rvalid) begin
                    failures++;
                    $display("FAIL rvalid_exclusive got m0_rvalid=1 m1_rvalid=1, expected at most one");
                end
            end
        end
    end

    task automatic master_read(input bit m, input logic [31:0] a);
        int n = 0;
        bit got;
        if (m) begin
            exp1_q.push_back(exp_for(a));
            m1_araddr = a;
            m1_arvalid = 1'b1;
        end else begin
            exp0_q.push_back(exp_for(a));
            m0_araddr = a;
            m0_arvalid = 1'b1;
        end
        #1;
        got = m ? m1_arready : m0_arready;
        while (!got && n < 200) begin
            @(negedge clk);
            #1;
            n++;
            got = m ? m1_arready : m0_arready;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL ar_timeout m%0d got arready=0, expected 1 within 200 cycles", m);
        end else begin
            grant_log.push_back(m);
        end
        @(negedge clk);
        if (m) m1_arvalid = 1'b0;
        else m0_arvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp0_q.size() != 0 || exp1_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got pending m0=%0d m1=%0d, expected 0 0", exp0_q.size(), exp1_q.size());
            exp0_q.delete();
            exp1_q.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m0_araddr = 32'h0; m1_araddr = 32'h0;
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        m0_rready = 1'b1;  m1_rready = 1'b1;
        s_arready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (dbg.state !== ST_IDLE || dbg.gnt !== 1'b0 || dbg.lastgnt !== 1'b1) begin
            failures++;
            $display("FAIL reset_state got state=%0d gnt=%b lastgnt=%b, expected 0 0 1", dbg.state, dbg.gnt, dbg.lastgnt);
        end
        checks++;
        if ({m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, s_rready} !== 6'b0) begin
            failures++;
            $display("FAIL reset_handshakes got %b, expected 000000",
                     {m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, s_rready});
        end
        checks++;
        if ({m0_rdata, m0_rresp, m1_rdata, m1_rresp, s_araddr} !== 100'h0) begin
            failures++;
            $display("FAIL reset_data got m0=%h/%b m1=%h/%b s_araddr=%h, expected all zero",
                     m0_rdata, m0_rresp, m1_rdata, m1_rresp, s_araddr);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        exp0_q.push_back({2'b00, 32'h0000_1234});
        m0_araddr = 32'ha000_0048;
        m0_arvalid = 1'b1;
        #1;
        checks++;
        if (m0_arready !== 1'b1 || m1_arready !== 1'b0 || s_arvalid !== 1'b0) begin
            failures++;
            $display("FAIL single_c0 got m0_arready=%b m1_arready=%b s_arvalid=%b, expected 1 0 0",
                     m0_arready, m1_arready, s_arvalid);
        end
        @(negedge clk);
        m0_arvalid = 1'b0;
        #1;
        checks++;
        if (s_arvalid !== 1'b1 || s_araddr !== 32'ha000_0048 || m0_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL single_c1 got s_arvalid=%b s_araddr=%h m0_rvalid=%b, expected 1 a0000048 0",
                     s_arvalid, s_araddr, m0_rvalid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0000_1234 || m0_rresp !== 2'b00) begin
            failures++;
            $display("FAIL single_c2 got rvalid=%b rdata=%h rresp=%b, expected 1 00001234 00",
                     m0_rvalid, m0_rdata, m0_rresp);
        end
        drain();
    endtask

    task automatic test_decerr();
        int av0 = s_av_cycles;
        master_read(1'b1, 32'h8000_0000);
        #1;
        checks++;
        if (m1_rvalid !== 1'b1 || m1_rresp !== 2'b11 || m1_rdata !== 32'h0 || s_arvalid !== 1'b0 || m0_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL decerr_resp got m1_rvalid=%b rresp=%b rdata=%h s_arvalid=%b m0_rvalid=%b, expected 1 11 0 0 0",
                     m1_rvalid, m1_rresp, m1_rdata, s_arvalid, m0_rvalid);
        end
        drain();
        checks++;
        if (s_av_cycles !== av0) begin
            failures++;
            $display("FAIL decerr_slave_quiet got s_arvalid cycles=%0d, expected %0d", s_av_cycles, av0);
        end
    endtask

    task automatic test_round_robin();
        bit order[4];
        order[0] = 1'b0; order[1] = 1'b1; order[2] = 1'b0; order[3] = 1'b1;
        grant_log.delete();
        for (int r = 0; r < 2; r++) begin
            fork
                master_read(1'b0, 32'ha000_0048 + 32'($urandom_range(0, 1)) * 4);
                master_read(1'b1, 32'ha000_0048 + 32'($urandom_range(0, 1)) * 4);
            join
        end
        drain();
        checks++;
        if (grant_log.size() != 4) begin
            failures++;
            $display("FAIL rr_count got grants=%0d, expected 4", grant_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (grant_log[i] !== order[i]) begin
                    failures++;
                    $display("FAIL rr_order[%0d] got m%0d, expected m%0d", i, grant_log[i], order[i]);
                end
            end
        end
    endtask

    task automatic test_range_edges();
        int av0 = s_av_cycles;
        master_read(1'b0, 32'ha000_004c);
        drain();
        checks++;
        if (s_av_cycles !== av0 + 1 || s_last_addr !== 32'ha000_004c) begin
            failures++;
            $display("FAIL range_upper got s_arvalid cycles=%0d addr=%h, expected %0d a000004c",
                     s_av_cycles, s_last_addr, av0 + 1);
        end
        av0 = s_av_cycles;
        master_read(1'b0, 32'ha000_0050);
        drain();
        checks++;
        if (s_av_cycles !== av0) begin
            failures++;
            $display("FAIL range_past_end got s_arvalid cycles=%0d, expected %0d", s_av_cycles, av0);
        end
    endtask

    task automatic test_reset_mid_ar();
        s_arready = 1'b0;
        m0_araddr = 32'ha000_0048;
        m0_arvalid = 1'b1;
        #1;
        checks++;
        if (m0_arready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_grant got m0_arready=%b, expected 1", m0_arready);
        end
        @(negedge clk);
        m0_arvalid = 1'b0;
        #1;
        checks++;
        if (dbg.state !== ST_AR || s_arvalid !== 1'b1 || dbg.lastgnt !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_ar got state=%0d s_arvalid=%b lastgnt=%b, expected 1 1 0",
                     dbg.state, s_arvalid, dbg.lastgnt);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (dbg.state !== ST_IDLE || dbg.lastgnt !== 1'b1 || dbg.gnt !== 1'b0 ||
            {s_arvalid, m0_rvalid, m1_rvalid, m0_arready, m1_arready} !== 5'b0) begin
            failures++;
            $display("FAIL rst_mid_after got state=%0d lastgnt=%b gnt=%b valids=%b, expected 0 1 0 00000",
                     dbg.state, dbg.lastgnt, dbg.gnt, {s_arvalid, m0_rvalid, m1_rvalid, m0_arready, m1_arready});
        end
        s_arready = 1'b1;
        master_read(1'b1, 32'ha000_0048);
        #1;
        checks++;
        if (dbg.gnt !== 1'b1 || dbg.state !== ST_AR) begin
            failures++;
            $display("FAIL rst_mid_regrant got gnt=%b state=%0d, expected 1 1", dbg.gnt, dbg.state);
        end
        drain();
    endtask

    task automatic test_rready_stall();
        m0_rready = 1'b0;
        exp0_q.push_back({2'b00, 32'h0000_1234});
        m0_araddr = 32'ha000_0048;
        m0_arvalid = 1'b1;
        #1;
        checks++;
        if (m0_arready !== 1'b1) begin
            failures++;
            $display("FAIL stall_grant got m0_arready=%b, expected 1", m0_arready);
        end
        @(negedge clk);
        m0_arvalid = 1'b0;
        exp1_q.push_back(exp_for(32'ha000_004c));
        m1_araddr = 32'ha000_004c;
        m1_arvalid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0000_1234 || m0_rresp !== 2'b00 ||
                s_rready !== 1'b0 || m1_arready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d] got rvalid=%b rdata=%h rresp=%b s_rready=%b m1_arready=%b, expected 1 00001234 00 0 0",
                         i, m0_rvalid, m0_rdata, m0_rresp, s_rready, m1_arready);
            end
            @(negedge clk);
        end
        m0_rready = 1'b1;
        #1;
        checks++;
        if (s_rready !== 1'b1 || m0_rvalid !== 1'b1) begin
            failures++;
            $display("FAIL stall_release got s_rready=%b m0_rvalid=%b, expected 1 1", s_rready, m0_rvalid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (m1_arready !== 1'b1 || m0_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL stall_next_grant got m1_arready=%b m0_rvalid=%b, expected 1 0", m1_arready, m0_rvalid);
        end
        @(negedge clk);
        m1_arvalid = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_decerr();
        test_round_robin();
        test_range_edges();
        test_reset_mid_ar();
        test_rready_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
